// File: rtl/soc_axi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : soc_axi_regfile
// Purpose  : AXI4 slave exposing a resettable byte register file (SoC straps:
//            GPIO, PAUSER, obfuscation key) and NUM_LOG log-FIFO channels.
//            Independent read (IDLE/FETCH/BEAT) and write (IDLE/DATA/RESP)
//            state machines; INCR/FIXED bursts, SLVERR decode.
// Ports    : aclk, rst            - clock, synchronous active-high reset
//            ar*/r*               - AXI4 read address / read data channels
//            aw*/w*/b*            - AXI4 write address / data / response
//            gpio_in              - value returned for reads of 0x008
//            gpio_out, pauser     - register bytes 3..0 and 15..12
//            cptra_obf_key        - register bytes 63..32
//            log_char/empty/full  - per-channel FWFT FIFO read side
//            log_rd               - per-channel one-cycle pop pulses
// Revision : 1.0 - initial release
// ============================================================================
module soc_axi_regfile #(
  parameter int TAGW      = 16,
  parameter int MEM_BYTES = 64,
  parameter int NUM_LOG   = 2,
  parameter int ADDRW     = 13
) (
  input  logic                   aclk,
  input  logic                   rst,
  // read address
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [31:0]            araddr,
  input  logic [TAGW-1:0]        arid,
  input  logic [7:0]             arlen,
  input  logic [1:0]             arburst,
  input  logic [2:0]             arsize,
  // read data
  output logic                   rvalid,
  input  logic                   rready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic [TAGW-1:0]        rid,
  output logic                   rlast,
  // write address
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            awaddr,
  input  logic [TAGW-1:0]        awid,
  input  logic [7:0]             awlen,
  input  logic [1:0]             awburst,
  input  logic [2:0]             awsize,
  // write data
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   wlast,
  // write response
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  output logic [TAGW-1:0]        bid,
  // SoC straps
  input  logic [31:0]            gpio_in,
  output logic [31:0]            gpio_out,
  output logic [31:0]            pauser,
  output logic [255:0]           cptra_obf_key,
  // log FIFO channels
  input  logic [8*NUM_LOG-1:0]   log_char,
  input  logic [NUM_LOG-1:0]     log_empty,
  input  logic [NUM_LOG-1:0]     log_full,
  output logic [NUM_LOG-1:0]     log_rd
);

  localparam int          MW            = $clog2(MEM_BYTES);
  localparam int          WAW           = ADDRW - 2;
  localparam logic [1:0]  C_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  C_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  C_BURST_FIXED = 2'b00;
  localparam logic [1:0]  C_BURST_WRAP  = 2'b10;
  localparam logic [31:0] C_LOG_BASE    = 32'h0000_1000;
  localparam logic [31:0] C_LOG_END     = C_LOG_BASE + 32'(8 * NUM_LOG);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_BEAT = 2'd2} rstate_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;

  // register file
  logic [7:0]         mem_q [MEM_BYTES];
  logic [7:0]         mem_d [MEM_BYTES];

  // read side state
  rstate_e            rstate_q, rstate_d;
  logic [TAGW-1:0]    rid_q, rid_d;
  logic [WAW-1:0]     raddr_q, raddr_d;   // word address
  logic [7:0]         rlen_q, rlen_d;
  logic [7:0]         rcnt_q, rcnt_d;
  logic               rfixed_q, rfixed_d;
  logic               rbad_q, rbad_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               rlast_q, rlast_d;
  logic [NUM_LOG-1:0] rpop_q, rpop_d;     // channel whose valid entry is on the bus
  logic [NUM_LOG-1:0] log_rd_q, log_rd_d;

  // write side state
  wstate_e            wstate_q, wstate_d;
  logic [TAGW-1:0]    bid_q, bid_d;
  logic [WAW-1:0]     waddr_q, waddr_d;
  logic [7:0]         wlen_q, wlen_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic               wfixed_q, wfixed_d;
  logic               wbad_q, wbad_d;
  logic               werr_q, werr_d;
  logic [1:0]         bresp_q, bresp_d;

  // combinational decode
  logic [31:0]        w_ra;
  logic [31:0]        w_wa;
  logic [31:0]        w_rd_data;
  logic [1:0]         w_rd_resp;
  logic [NUM_LOG-1:0] w_rd_pop;
  logic               w_wr_err;
  logic               w_unused;

  assign w_unused = ^{araddr[31:ADDRW], araddr[1:0], awaddr[31:ADDRW], awaddr[1:0], wlast};

  assign w_ra     = 32'({raddr_q, 2'b00});
  assign w_wa     = 32'({waddr_q, 2'b00});
  assign w_wr_err = wbad_q | (w_wa >= 32'(MEM_BYTES));

  // --------------------------------------------------------------------------
  // Read data decode for the current read address
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_data = 32'h0;
    w_rd_resp = C_RESP_SLVERR;
    w_rd_pop  = '0;
    if (!rbad_q) begin
      if (w_ra < 32'(MEM_BYTES)) begin
        w_rd_resp = C_RESP_OKAY;
        if (w_ra == 32'h8) begin
          w_rd_data = gpio_in;
        end else begin
          for (int b = 0; b < 4; b++) begin
            w_rd_data[8*b +: 8] = mem_q[{raddr_q[MW-3:0], 2'(b)}];
          end
        end
      end else if (w_ra >= C_LOG_BASE && w_ra < C_LOG_END) begin
        w_rd_resp = C_RESP_OKAY;
        for (int n = 0; n < NUM_LOG; n++) begin
          if (w_ra[5:3] == 3'(n)) begin
            if (w_ra[2]) begin
              w_rd_data = {30'h0, log_full[n], log_empty[n]};
            end else begin
              w_rd_data   = {23'h0, ~log_empty[n], log_char[8*n +: 8]};
              // only an entry that was actually presented may be popped
              w_rd_pop[n] = ~log_empty[n];
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_comb begin
    rstate_d = rstate_q;
    rid_d    = rid_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rfixed_d = rfixed_q;
    rbad_d   = rbad_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rpop_d   = rpop_q;
    log_rd_d = '0;
    arready  = 1'b0;
    rvalid   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          rid_d    = arid;
          raddr_d  = araddr[ADDRW-1:2];
          rlen_d   = arlen;
          rcnt_d   = 8'h0;
          rfixed_d = (arburst == C_BURST_FIXED);
          rbad_d   = (arsize != 3'd2) || (arburst == C_BURST_WRAP);
          rstate_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rdata_d  = w_rd_data;
        rresp_d  = w_rd_resp;
        rpop_d   = w_rd_pop;
        rlast_d  = (rcnt_q == rlen_q);
        rstate_d = R_BEAT;
      end
      R_BEAT: begin
        rvalid = 1'b1;
        if (rready) begin
          log_rd_d = rpop_q;
          if (rlast_q) begin
            rlast_d  = 1'b0;
            rstate_d = R_IDLE;
          end else begin
            rcnt_d   = rcnt_q + 8'd1;
            if (!rfixed_q) raddr_d = raddr_q + WAW'(1);
            rstate_d = R_FETCH;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_comb begin
    wstate_d = wstate_q;
    bid_d    = bid_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    wfixed_d = wfixed_q;
    wbad_d   = wbad_q;
    werr_d   = werr_q;
    bresp_d  = bresp_q;
    mem_d    = mem_q;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          bid_d    = awid;
          waddr_d  = awaddr[ADDRW-1:2];
          wlen_d   = awlen;
          wcnt_d   = 8'h0;
          wfixed_d = (awburst == C_BURST_FIXED);
          wbad_d   = (awsize != 3'd2) || (awburst == C_BURST_WRAP);
          werr_d   = 1'b0;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          if (!w_wr_err) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb[b]) mem_d[{waddr_q[MW-3:0], 2'(b)}] = wdata[8*b +: 8];
            end
          end
          werr_d = werr_q | w_wr_err;
          // the beat count, not wlast, terminates the burst
          if (wcnt_q == wlen_q) begin
            bresp_d  = (werr_q | w_wr_err) ? C_RESP_SLVERR : C_RESP_OKAY;
            wstate_d = W_RESP;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            if (!wfixed_q) waddr_d = waddr_q + WAW'(1);
          end
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      raddr_q  <= '0;
      rlen_q   <= 8'h0;
      rcnt_q   <= 8'h0;
      rfixed_q <= 1'b0;
      rbad_q   <= 1'b0;
      rdata_q  <= 32'h0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
      rpop_q   <= '0;
      log_rd_q <= '0;
      wstate_q <= W_IDLE;
      bid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= 8'h0;
      wcnt_q   <= 8'h0;
      wfixed_q <= 1'b0;
      wbad_q   <= 1'b0;
      werr_q   <= 1'b0;
      bresp_q  <= 2'b00;
      for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= 8'h00;
    end else begin
      rstate_q <= rstate_d;
      rid_q    <= rid_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rfixed_q <= rfixed_d;
      rbad_q   <= rbad_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rpop_q   <= rpop_d;
      log_rd_q <= log_rd_d;
      wstate_q <= wstate_d;
      bid_q    <= bid_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wfixed_q <= wfixed_d;
      wbad_q   <= wbad_d;
      werr_q   <= werr_d;
      bresp_q  <= bresp_d;
      mem_q    <= mem_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign rid      = rid_q;
  assign rlast    = rlast_q;
  assign bresp    = bresp_q;
  assign bid      = bid_q;
  assign log_rd   = log_rd_q;
  assign gpio_out = {mem_q[3], mem_q[2], mem_q[1], mem_q[0]};
  assign pauser   = {mem_q[15], mem_q[14], mem_q[13], mem_q[12]};

  for (genvar gi = 0; gi < 32; gi++) begin : g_key
    assign cptra_obf_key[8*gi +: 8] = mem_q[32+gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_axi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_axi_regfile
// Purpose  : Directed self-checking bench for soc_axi_regfile with a small
//            first-word-fallthrough log-FIFO model on channels 0 and 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_axi_regfile;

  logic         aclk = 1'b0;
  logic         rst;
  logic         arvalid, arready;
  logic [31:0]  araddr;
  logic [15:0]  arid;
  logic [7:0]   arlen;
  logic [1:0]   arburst;
  logic [2:0]   arsize;
  logic         rvalid, rready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic [15:0]  rid;
  logic         rlast;
  logic         awvalid, awready;
  logic [31:0]  awaddr;
  logic [15:0]  awid;
  logic [7:0]   awlen;
  logic [1:0]   awburst;
  logic [2:0]   awsize;
  logic         wvalid, wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic [15:0]  bid;
  logic [31:0]  gpio_in, gpio_out, pauser;
  logic [255:0] cptra_obf_key;
  logic [15:0]  log_char;
  logic [1:0]   log_empty, log_full, log_rd;

  always #5 aclk = ~aclk;

  soc_axi_regfile #(.TAGW(16), .MEM_BYTES(64), .NUM_LOG(2), .ADDRW(13)) dut (
    .aclk(aclk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arburst(arburst), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rid(rid), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awburst(awburst), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .pauser(pauser),
    .cptra_obf_key(cptra_obf_key),
    .log_char(log_char), .log_empty(log_empty), .log_full(log_full), .log_rd(log_rd)
  );

  // --------------------------------------------------------------------------
  // FWFT FIFO model: the main flow appends entries (f_mem/f_wr), this process
  // owns the read pointer. A pop pulse is consumed mid-cycle so the next entry
  // is presented before the following fetch edge; an empty FIFO keeps showing
  // its last character.
  // --------------------------------------------------------------------------
  logic [7:0] f_mem [2][16];
  int         f_wr [2]   = '{0, 0};
  int         f_rd [2]   = '{0, 0};
  int         pops [2]   = '{0, 0};
  logic [7:0] f_last [2] = '{8'h00, 8'h00};
  logic       full0      = 1'b0;

  always @(negedge aclk) begin
    for (int n = 0; n < 2; n++) begin
      if (log_rd[n]) begin
        pops[n]++;
        if (f_rd[n] < f_wr[n]) f_rd[n]++;
      end
      if (f_rd[n] < f_wr[n]) f_last[n] = f_mem[n][f_rd[n]];
      log_char[8*n +: 8] = f_last[n];
      log_empty[n]       = !(f_rd[n] < f_wr[n]);
    end
    log_full = {1'b0, full0};
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // captured read beats / write response
  logic [31:0] rb_data [16];
  logic [1:0]  rb_resp [16];
  logic        rb_last [16];
  logic [15:0] rb_id   [16];
  logic [1:0]  wb_resp;
  logic [15:0] wb_id;

  task automatic axi_read(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int stall);
    int k;
    logic [31:0] hold;
    int p;
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst; arsize = size;
    @(negedge aclk);
    k = 0;
    while (!arready && k < 20) begin @(negedge aclk); k++; end
    check("arready", 64'(arready), 64'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk);
    check("rd_fetch_gap", 64'(rvalid), 64'd0);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge aclk);
      k = 0;
      while (!rvalid && k < 20) begin @(negedge aclk); k++; end
      check("rvalid", 64'(rvalid), 64'd1);
      check(i == 0 ? "rd_latency" : "rd_rate", 64'(k), i == 0 ? 64'd0 : 64'd1);
      if (i == 0 && stall > 0) begin
        hold = rdata;
        p    = pops[0] + pops[1];
        for (int s = 0; s < stall; s++) begin
          @(negedge aclk);
          check("stall_rdata", 64'(rdata), 64'(hold));
          check("stall_nopop", 64'(pops[0] + pops[1]), 64'(p));
        end
      end
      rb_data[i] = rdata; rb_resp[i] = rresp; rb_last[i] = rlast; rb_id[i] = rid;
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input logic [31:0] d0, input logic [31:0] step, input logic [3:0] strb);
    int k;
    @(posedge aclk); #1;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size;
    @(negedge aclk);
    k = 0;
    while (!awready && k < 20) begin @(negedge aclk); k++; end
    check("awready", 64'(awready), 64'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    check("wready_latency", 64'(wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = d0 + step * 32'(i); wstrb = strb; wlast = (i == int'(len));
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge aclk);
    check("bvalid_latency", 64'(bvalid), 64'd1);
    wb_resp = bresp; wb_id = bid;
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk);
    check("bvalid_clear", 64'(bvalid), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int p;
    rst = 1'b1;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; arsize = 0; rready = 0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0; awsize = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    gpio_in = 32'hDEAD_BEEF;

    // ---- reset values
    repeat (3) @(negedge aclk);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rdata",  64'(rdata), 64'd0);
    check("rst_resp",   64'({rresp, bresp}), 64'd0);
    check("rst_ids",    64'({rid, bid}), 64'd0);
    check("rst_rlast",  64'(rlast), 64'd0);
    check("rst_log_rd", 64'(log_rd), 64'd0);
    check("rst_gpio",   64'(gpio_out), 64'd0);
    check("rst_pauser", 64'(pauser), 64'd0);
    check("rst_key",    64'(|cptra_obf_key), 64'd0);
    @(posedge aclk); #1;
    rst = 1'b0;
    @(negedge aclk);
    check("idle_ready", 64'({arready, awready}), 64'h3);

    // ---- strobed single write to GPIO
    axi_write(32'h0, 16'h1234, 8'd0, 2'b01, 3'd2, 32'hA5A5_1234, 32'd0, 4'b0101);
    check("gpio_strb", 64'(gpio_out), 64'h00A5_0034);
    check("b_okay",    64'(wb_resp), 64'd0);
    check("bid",       64'(wb_id), 64'h1234);

    // ---- INCR burst into the key bytes, then read back
    axi_write(32'h20, 16'h0021, 8'd7, 2'b01, 3'd2, 32'd1, 32'd1, 4'hF);
    check("key_lo", cptra_obf_key[63:0], 64'h0000_0002_0000_0001);
    check("key_hi", 64'(cptra_obf_key[255:224]), 64'h8);
    check("burst_b", 64'(wb_resp), 64'd0);
    axi_read(32'h20, 16'h0055, 8'd7, 2'b01, 3'd2, 0);
    for (int i = 0; i < 8; i++) begin
      check("burst_rdata", 64'(rb_data[i]), 64'(i + 1));
      check("burst_rlast", 64'(rb_last[i]), 64'(i == 7));
      check("burst_rresp", 64'(rb_resp[i]), 64'd0);
    end
    check("burst_rid", 64'(rb_id[7]), 64'h55);

    // ---- PAUSER bytes and GPIO input readback
    axi_write(32'hC, 16'h0007, 8'd0, 2'b01, 3'd2, 32'hCAFE_F00D, 32'd0, 4'hF);
    check("pauser", 64'(pauser), 64'hCAFE_F00D);
    axi_read(32'h8, 16'h0008, 8'd0, 2'b01, 3'd2, 0);
    check("gpio_in_rd", 64'(rb_data[0]), 64'hDEAD_BEEF);

    // ---- FIXED burst on log channel 1: two entries then empty
    f_mem[1][0] = 8'h41; f_mem[1][1] = 8'h42; f_wr[1] = 2;
    repeat (2) @(negedge aclk);
    #1 p = pops[1];
    axi_read(32'h1008, 16'h0009, 8'd3, 2'b00, 3'd2, 0);
    check("log1_b0", 64'(rb_data[0]), 64'h141);
    check("log1_b1", 64'(rb_data[1]), 64'h142);
    check("log1_b2", 64'(rb_data[2]), 64'h042);
    check("log1_b3", 64'(rb_data[3]), 64'h042);
    check("log1_rlast", 64'({rb_last[3], rb_last[2], rb_last[1], rb_last[0]}), 64'b1000);
    @(negedge aclk); #1;
    check("log1_pops", 64'(pops[1] - p), 64'd2);
    axi_read(32'h100C, 16'h000A, 8'd0, 2'b01, 3'd2, 0);
    check("log1_status", 64'(rb_data[0]), 64'h1);

    // ---- stalled read on channel 0: no pop until the handshake
    f_mem[0][0] = 8'h33; f_mem[0][1] = 8'h44; f_wr[0] = 2; full0 = 1'b1;
    repeat (2) @(negedge aclk);
    #1 p = pops[0];
    axi_read(32'h1000, 16'h0003, 8'd0, 2'b01, 3'd2, 10);
    check("log0_stall_data", 64'(rb_data[0]), 64'h133);
    @(negedge aclk); #1;
    check("log0_one_pop", 64'(pops[0] - p), 64'd1);
    axi_read(32'h1004, 16'h0004, 8'd0, 2'b01, 3'd2, 0);
    check("log0_status", 64'(rb_data[0]), 64'h2);
    axi_read(32'h1000, 16'h0005, 8'd0, 2'b01, 3'd2, 0);
    check("log0_next", 64'(rb_data[0]), 64'h144);
    axi_read(32'h1010, 16'h0006, 8'd0, 2'b01, 3'd2, 0);
    check("log_oob_resp", 64'(rb_resp[0]), 64'd2);

    // ---- error decode
    axi_read(32'h0800, 16'h0011, 8'd0, 2'b01, 3'd2, 0);
    check("slv_rd_data", 64'(rb_data[0]), 64'd0);
    check("slv_rd_resp", 64'(rb_resp[0]), 64'd2);
    axi_read(32'h0, 16'h0012, 8'd0, 2'b10, 3'd2, 0);
    check("wrap_rd", 64'({rb_resp[0], rb_data[0]}), {30'h0, 2'b10, 32'h0});
    axi_write(32'h0, 16'h0077, 8'd0, 2'b01, 3'd1, 32'hFFFF_FFFF, 32'd0, 4'hF);
    check("slv_wr_resp", 64'(wb_resp), 64'd2);
    check("slv_wr_bid",  64'(wb_id), 64'h77);
    check("slv_wr_keep", 64'(gpio_out), 64'h00A5_0034);
    axi_write(32'h0800, 16'h0078, 8'd0, 2'b01, 3'd2, 32'h1, 32'd0, 4'hF);
    check("oob_wr_resp", 64'(wb_resp), 64'd2);

    // ---- reset during beat 3 of an 8-beat read
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = 32'h20; arid = 16'h0099; arlen = 8'd7; arburst = 2'b01; arsize = 3'd2;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      k = 0;
      while (!rvalid && k < 20) begin @(negedge aclk); k++; end
      check("mid_rvalid", 64'(rvalid), 64'd1);
      if (i < 2) begin
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
      end
    end
    check("mid_beat3", 64'(rdata), 64'd3);
    rst = 1'b1;
    @(negedge aclk);
    check("mid_rvalid0", 64'(rvalid), 64'd0);
    check("mid_rdata0",  64'({rlast, rresp, rdata}), 64'd0);
    check("mid_outs0",   64'({gpio_out, pauser}), 64'd0);
    check("mid_key0",    64'(|cptra_obf_key), 64'd0);
    check("mid_rid0",    64'({rid, bid}), 64'd0);
    @(posedge aclk); #1;
    rst = 1'b0;
    @(negedge aclk);
    check("mid_arready", 64'({arready, awready, bvalid, log_rd}), 64'b11000);
    axi_read(32'h20, 16'h00AB, 8'd0, 2'b01, 3'd2, 0);
    check("post_rst_data", 64'(rb_data[0]), 64'd0);
    check("post_rst_id",   64'(rb_id[0]), 64'hAB);
    check("post_rst_last", 64'(rb_last[0]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/soc_axi_regfile.md
# soc_axi_regfile

Parametrised AXI4 slave that replaces the single-beat, always-ready SoC adapter on the FPGA wrapper. It adds full AR/R and AW/W/B handshakes, INCR/FIXED bursts, SLVERR decode, a resettable register file, and `NUM_LOG` independent first-word-fallthrough log-FIFO channels. The host reaches Caliptra SoC straps and log channels through it: GPIO, PAUSER, obfuscation key, and log FIFOs.

## Interface
- `TAGW`, 16, AXI ID width.
- `MEM_BYTES`, 64, register-file size in bytes; power of 2, minimum 64.
- `NUM_LOG`, 2, log FIFO channel count, 1..8.
- `ADDRW`, 13, decoded address bits; upper bits are ignored.
- `aclk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `arvalid/arready/araddr[31:0]/arid[TAGW]/arlen[8]/arburst[2]/arsize[3]`: AXI4 read address channel.
- `rvalid/rready/rdata[32]/rresp[2]/rid[TAGW]/rlast`: AXI4 read data channel.
- `awvalid/awready/awaddr[32]/awid/awlen/awburst/awsize`: AXI4 write address channel.
- `wvalid/wready/wdata[32]/wstrb[4]/wlast`: AXI4 write data channel.
- `bvalid/bready/bresp[2]/bid[TAGW]`: AXI4 write response channel.
- `gpio_in` in 32, `gpio_out` out 32, `pauser` out 32, `cptra_obf_key` out 256.
- `log_char` in 8*NUM_LOG; `log_empty`, `log_full` in NUM_LOG; `log_rd` out NUM_LOG, one-cycle pop pulses.

## Operation
- **Address map** (`a = addr[ADDRW-1:0]`, word-aligned; `a[1:0]` is ignored):
  - 0..MEM_BYTES-1: R/W register bytes, little-endian, except that reads of 0x008 return `gpio_in`.
  - 0x1000+8n: channel n data read = `{16'h0, 7'h0, ~log_empty[n], log_char[n]}`.
  - 0x1004+8n: channel n status read = `{30'h0, log_full[n], log_empty[n]}`.
  - Any other address: read data 0 with SLVERR (2'b10); writes are dropped with SLVERR.
- **Burst rules:** `arsize`/`awsize` != 2 or burst WRAP (2'b10) makes every beat SLVERR, with no side effects. INCR advances the address by 4 per beat; FIXED holds it.
- **Read FSM R_IDLE -> R_FETCH -> R_BEAT:**
  - R_IDLE: `arready` = 1. An AR handshake latches id, addr, len and burst, then goes to R_FETCH.
  - R_FETCH: `rvalid` = 0; register `rdata`/`rresp` from the current address; go to R_BEAT.
  - R_BEAT: `rvalid` = 1, held stable until `rready`. `rlast` = 1 when beat count == len. On handshake: if last, go to R_IDLE; else advance the address and return to R_FETCH.
- **Log pop:** `log_rd[n]` pulses for the one cycle after an R handshake of a channel-n data beat whose latched valid bit was 1. A pop happens only on handshake, never on request.
- **Write FSM W_IDLE -> W_DATA -> W_RESP:**
  - W_IDLE: `awready` = 1, `wready` = 0. An AW handshake latches the fields.
  - W_DATA: `wready` = 1. Each W handshake writes the `wstrb` bytes if the address is in range, otherwise sets a sticky error. After beat awlen, go to W_RESP. `wlast` is ignored for termination.
  - W_RESP: `bvalid` = 1 with `bresp` OKAY or SLVERR (sticky over the burst) and `bid`; hold until `bready`, then go to W_IDLE.
- **Outputs:** `gpio_out` = bytes 3..0; `pauser` = bytes 15..12; `cptra_obf_key[8i+7:8i]` = byte 32+i.
- The read and write FSMs are independent. A write committed in cycle t is visible to an R_FETCH in cycle t+1 or later; a same-cycle fetch sees the old value.

## Timing
- **Reset:** all register bytes are 0, both FSMs are idle, and all of the following are 0: `rvalid`, `bvalid`, `rlast`, `rdata`, `rresp`, `bresp`, `rid`, `bid`, `log_rd`, `gpio_out`, `pauser`, `cptra_obf_key`.
- **Reset mid-burst:** the burst aborts with no further beats, no B response and no pop; `arready` and `awready` read 1 the cycle after `rst` falls.
- **Read latency:** first `rvalid` is 2 cycles after the AR handshake. Sustained rate is one beat per 2 cycles.
- **Write latency:** `wready` is 1 cycle after the AW handshake. `bvalid` is 1 cycle after the final W handshake.
- **Flow control:** `rready`/`bready` low stalls indefinitely with outputs stable.
- **FIFO data path:** the FIFO is first-word-fallthrough, so the next `log_char` is valid by the next R_FETCH.
- **Empty channel:** reads of an empty channel return valid = 0 and do not pop; repeated reads are safe.

## Test plan
- Reset, then write 0xA5A5_1234 with `wstrb` 4'b0101 to 0x0 -> `gpio_out` = 0x00A5_0034, B OKAY with `bid` matching `awid`, `bvalid` 1 cycle after the W handshake.
- INCR `awlen` 7 at 0x20 writing i+1 per beat, then read `arlen` 7 -> `cptra_obf_key[63:0]` = 0x0000_0002_0000_0001, R beats return 1..8, `rlast` only on beat 8.
- FIXED `arlen` 3 at 0x1008 with channel 1 holding 0x41, 0x42 and then empty -> data 0x141, 0x142, 0x042, 0x042; exactly two `log_rd[1]` pulses.
- Read 0x1000 with `rready` held low for 10 cycles -> `rdata` stable, no pop until the handshake; one pop after it.
- Read 0x0800 and `awsize` = 1 write to 0x0 -> SLVERR, rdata 0, register unchanged.
- Assert `rst` during beat 3 of an 8-beat read -> `rvalid` 0 the next cycle, all outputs return to reset values, and a new AR is accepted immediately.
